// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the instruction-fetch port, the data port and the
//   single-ported memory port seen by mem_port_arbiter.
//   slave  : view used by the arbiter
//   master : view used by the pipeline/memory side (stimulus)
//   Fetch  : IReq, IAddr -> IRdata, IReady
//   Data   : DReq, DWe, DAddr, DWdata -> DRdata, DReady
//   Memory : MemEn, MemWe, MemAddr, MemWdata <- MemRdata
//   Status : Busy
interface mem_port_arbiter_if;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] IRdata;
  logic        IReady;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWdata;
  logic [31:0] DRdata;
  logic        DReady;
  logic        MemEn;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;
  logic        Busy;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata,
    output IRdata, IReady, DRdata, DReady,
    output MemEn, MemWe, MemAddr, MemWdata, Busy
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata,
    input  IRdata, IReady, DRdata, DReady,
    input  MemEn, MemWe, MemAddr, MemWdata, Busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between an instruction-fetch port and
//   a data port. One access at a time: IDLE arbitrates, ACCESS holds the
//   memory for WAIT_CYCLES cycles, DONE pulses the granted port's Ready.
//   Ports:
//     Clock  : processor clock, rising-edge
//     Reset_ : asynchronous, active-low reset
//     bus    : mem_port_arbiter_if.slave (fetch, data, memory, Busy)
//
//   state  | meaning
//   IDLE   | no access in flight; arbitrate and latch the winner
//   ACCESS | memory enabled with latched address/data, counter running
//   DONE   | one-cycle Ready pulse to the granted port
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic              Clock,
  input logic              Reset_,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last_d;
  logic        gnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] irdata_q;
  logic [31:0] drdata_q;
  logic        any_req;
  logic        grant_d;
  logic        last_cycle;

  assign any_req    = bus.IReq | bus.DReq;
  // Data wins a tie unless the previous tie also went to data.
  assign grant_d    = bus.DReq & ~(bus.IReq & last_d);
  assign last_cycle = (cnt == 4'd0);

  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (last_cycle) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.MemEn  = 1'b0;
    bus.MemWe  = 1'b0;
    bus.IReady = 1'b0;
    bus.DReady = 1'b0;
    bus.Busy   = 1'b1;
    case (state)
      IDLE:   bus.Busy = 1'b0;
      ACCESS: begin
        bus.MemEn = 1'b1;
        bus.MemWe = gnt_d & we_q;
      end
      DONE: begin
        bus.IReady = ~gnt_d;
        bus.DReady = gnt_d;
      end
      default: bus.Busy = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      cnt      <= 4'd0;
      last_d   <= 1'b0;
      gnt_d    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      irdata_q <= 32'd0;
      drdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cnt     <= CNT_LOAD;
            gnt_d   <= grant_d;
            addr_q  <= grant_d ? bus.DAddr : bus.IAddr;
            wdata_q <= grant_d ? bus.DWdata : 32'd0;
            we_q    <= grant_d & bus.DWe;
            // A lone data request leaves the fairness flag untouched.
            if (grant_d && bus.IReq) last_d <= 1'b1;
            else if (!grant_d)       last_d <= 1'b0;
          end
        end
        ACCESS: begin
          if (last_cycle) begin
            if (!we_q) begin
              if (gnt_d) drdata_q <= bus.MemRdata;
              else       irdata_q <= bus.MemRdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.MemAddr  = addr_q;
  assign bus.MemWdata = wdata_q;
  assign bus.IRdata   = irdata_q;
  assign bus.DRdata   = drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  typedef struct {
    int          sel;
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] rdata;
    logic        exp_d;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_ir;
    logic [31:0] exp_dr;
  } vec_t;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata, mem_rdata;

  logic        o_memen, o_memwe, o_irdy, o_drdy, o_busy;
  logic [31:0] o_addr, o_wdata, o_ir, o_dr;

  int n_tests;
  int n_fail;

  mem_port_arbiter_if b2();
  mem_port_arbiter_if b1();
  mem_port_arbiter_if b15();

  mem_port_arbiter #(.WAIT_CYCLES(2))  dut2  (.Clock(clk), .Reset_(rst_n), .bus(b2));
  mem_port_arbiter #(.WAIT_CYCLES(1))  dut1  (.Clock(clk), .Reset_(rst_n), .bus(b1));
  mem_port_arbiter #(.WAIT_CYCLES(15)) dut15 (.Clock(clk), .Reset_(rst_n), .bus(b15));

  assign b2.IReq      = ireq && (sel == 0);
  assign b2.DReq      = dreq && (sel == 0);
  assign b2.DWe       = dwe;
  assign b2.IAddr     = iaddr;
  assign b2.DAddr     = daddr;
  assign b2.DWdata    = dwdata;
  assign b2.MemRdata  = mem_rdata;
  assign b1.IReq      = ireq && (sel == 1);
  assign b1.DReq      = dreq && (sel == 1);
  assign b1.DWe       = dwe;
  assign b1.IAddr     = iaddr;
  assign b1.DAddr     = daddr;
  assign b1.DWdata    = dwdata;
  assign b1.MemRdata  = mem_rdata;
  assign b15.IReq     = ireq && (sel == 2);
  assign b15.DReq     = dreq && (sel == 2);
  assign b15.DWe      = dwe;
  assign b15.IAddr    = iaddr;
  assign b15.DAddr    = daddr;
  assign b15.DWdata   = dwdata;
  assign b15.MemRdata = mem_rdata;

  always_comb begin
    o_memen = b2.MemEn;  o_memwe = b2.MemWe;  o_addr = b2.MemAddr;
    o_wdata = b2.MemWdata; o_ir = b2.IRdata; o_dr = b2.DRdata;
    o_irdy  = b2.IReady; o_drdy = b2.DReady; o_busy = b2.Busy;
    if (sel == 1) begin
      o_memen = b1.MemEn;  o_memwe = b1.MemWe;  o_addr = b1.MemAddr;
      o_wdata = b1.MemWdata; o_ir = b1.IRdata; o_dr = b1.DRdata;
      o_irdy  = b1.IReady; o_drdy = b1.DReady; o_busy = b1.Busy;
    end else if (sel == 2) begin
      o_memen = b15.MemEn;  o_memwe = b15.MemWe;  o_addr = b15.MemAddr;
      o_wdata = b15.MemWdata; o_ir = b15.IRdata; o_dr = b15.DRdata;
      o_irdy  = b15.IReady; o_drdy = b15.DReady; o_busy = b15.Busy;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int s);
    if (s == 1) return 1;
    if (s == 2) return 15;
    return 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge with the selected DUT idle.
  task automatic run_vec(input vec_t v, input string tag);
    int   w;
    int   c;
    int   en_cnt, rdy_cyc, addr_bad, we_bad, wd_bad, busy_bad, both;
    logic got_d;
    w = wait_of(v.sel);
    c = 0; en_cnt = 0; rdy_cyc = 0; addr_bad = 0; we_bad = 0;
    wd_bad = 0; busy_bad = 0; both = 0; got_d = 1'b0;
    sel = v.sel;
    chk({tag, " idle_busy"}, {31'd0, o_busy}, 32'd0);
    ireq = v.ireq; dreq = v.dreq; dwe = v.dwe;
    iaddr = v.iaddr; daddr = v.daddr; dwdata = v.dwdata; mem_rdata = v.rdata;
    while (rdy_cyc == 0 && c < 40) begin
      c++;
      @(negedge clk);
      if (!o_busy) busy_bad++;
      if (o_irdy && o_drdy) both++;
      if (o_memen) begin
        en_cnt++;
        if (o_addr !== v.exp_addr) addr_bad++;
        if (o_memwe !== v.exp_we) we_bad++;
        if (v.exp_we && (o_wdata !== v.dwdata)) wd_bad++;
      end
      if (o_irdy || o_drdy) begin
        rdy_cyc = c;
        got_d   = o_drdy;
      end
    end
    chk({tag, " ready_cycle"}, rdy_cyc, w + 1);
    chk({tag, " memen_cycles"}, en_cnt, w);
    chk({tag, " grant_is_data"}, {31'd0, got_d}, {31'd0, v.exp_d});
    chk({tag, " addr_errs"}, addr_bad, 0);
    chk({tag, " memwe_errs"}, we_bad, 0);
    chk({tag, " wdata_errs"}, wd_bad, 0);
    chk({tag, " busy_errs"}, busy_bad, 0);
    chk({tag, " both_ready"}, both, 0);
    chk({tag, " irdata"}, o_ir, v.exp_ir);
    chk({tag, " drdata"}, o_dr, v.exp_dr);
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    @(negedge clk);
    chk({tag, " busy_after"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic contention();
    int   c;
    int   n;
    int   both;
    int   cyc [4];
    logic isd [4];
    c = 0; n = 0; both = 0;
    sel = 0;
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b0;
    iaddr = 32'h80; daddr = 32'h400; mem_rdata = 32'hCAFE0001;
    while (n < 4 && c < 40) begin
      c++;
      @(negedge clk);
      if (o_irdy && o_drdy) both++;
      if (o_irdy || o_drdy) begin
        cyc[n] = c;
        isd[n] = o_drdy;
        n++;
      end
    end
    ireq = 1'b0; dreq = 1'b0;
    chk("cont ready_count", n, 4);
    chk("cont both_ready", both, 0);
    if (n == 4) begin
      chk("cont first_cycle", cyc[0], 3);
      chk("cont grant0_d", {31'd0, isd[0]}, 32'd1);
      chk("cont grant1_d", {31'd0, isd[1]}, 32'd0);
      chk("cont grant2_d", {31'd0, isd[2]}, 32'd1);
      chk("cont grant3_d", {31'd0, isd[3]}, 32'd0);
      for (int k = 1; k < 4; k++)
        chk($sformatf("cont spacing%0d", k), cyc[k] - cyc[k-1], 4);
    end
    @(negedge clk);
    chk("cont busy_after", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic reset_mid_access();
    vec_t v;
    sel = 0;
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b1;
    iaddr = 32'h90; daddr = 32'h1F0; dwdata = 32'h13572468; mem_rdata = 32'h600DC0DE;
    @(negedge clk);
    chk("rst pre_memwe", {31'd0, o_memwe}, 32'd1);
    chk("rst pre_addr", o_addr, 32'h1F0);
    #2 rst_n = 1'b0;
    dreq = 1'b0; dwe = 1'b0;
    #1;
    chk("rst memen", {31'd0, o_memen}, 32'd0);
    chk("rst memwe", {31'd0, o_memwe}, 32'd0);
    chk("rst memaddr", o_addr, 32'd0);
    chk("rst memwdata", o_wdata, 32'd0);
    chk("rst irdata", o_ir, 32'd0);
    chk("rst drdata", o_dr, 32'd0);
    chk("rst ready", {30'd0, o_irdy, o_drdy}, 32'd0);
    chk("rst busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk("rst held_drdy", {31'd0, o_drdy}, 32'd0);
    rst_n = 1'b1;
    v = '{0, 1'b1, 1'b0, 1'b0, 32'h90, 32'h0, 32'h0, 32'h600DC0DE,
          1'b0, 32'h90, 1'b0, 32'h600DC0DE, 32'h0};
    run_vec(v, "rst_then_fetch");
  endtask

  vec_t vecs [12];

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; sel = 0;
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    iaddr = '0; daddr = '0; dwdata = '0; mem_rdata = '0;

    //          sel ireq dreq dwe  iaddr   daddr    dwdata        rdata         exp_d exp_addr exp_we exp_ir        exp_dr
    vecs[0]  = '{0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0,        32'h8C010004, 1'b0, 32'h40,  1'b0, 32'h8C010004, 32'h0};
    vecs[1]  = '{0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h100, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 32'h100, 1'b1, 32'h8C010004, 32'h0};
    vecs[2]  = '{0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h200, 32'h0,        32'h12345678, 1'b1, 32'h200, 1'b0, 32'h8C010004, 32'h12345678};
    vecs[3]  = '{0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h300, 32'h0,        32'hAAAA5555, 1'b1, 32'h300, 1'b0, 32'h8C010004, 32'hAAAA5555};
    vecs[4]  = '{0, 1'b1, 1'b1, 1'b0, 32'h48, 32'h304, 32'h0,        32'h0BADF00D, 1'b0, 32'h48,  1'b0, 32'h0BADF00D, 32'hAAAA5555};
    vecs[5]  = '{0, 1'b1, 1'b1, 1'b1, 32'h4C, 32'h308, 32'h5A5A5A5A, 32'h77777777, 1'b1, 32'h308, 1'b1, 32'h0BADF00D, 32'hAAAA5555};
    vecs[6]  = '{0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h30C, 32'h0,        32'h11112222, 1'b1, 32'h30C, 1'b0, 32'h0BADF00D, 32'h11112222};
    vecs[7]  = '{0, 1'b1, 1'b0, 1'b0, 32'h50, 32'h0,   32'h0,        32'h22223333, 1'b0, 32'h50,  1'b0, 32'h22223333, 32'h11112222};
    vecs[8]  = '{0, 1'b1, 1'b1, 1'b0, 32'h54, 32'h310, 32'h0,        32'h44445555, 1'b1, 32'h310, 1'b0, 32'h22223333, 32'h44445555};
    vecs[9]  = '{0, 1'b1, 1'b0, 1'b0, 32'h58, 32'h0,   32'h0,        32'h66667777, 1'b0, 32'h58,  1'b0, 32'h66667777, 32'h44445555};
    vecs[10] = '{1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h20,  32'h0,        32'h0F0F0F0F, 1'b1, 32'h20,  1'b0, 32'h0,        32'h0F0F0F0F};
    vecs[11] = '{2, 1'b0, 1'b1, 1'b0, 32'h0,  32'h24,  32'h0,        32'hF0F0F0F0, 1'b1, 32'h24,  1'b0, 32'h0,        32'hF0F0F0F0};

    @(negedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, o_busy}, 32'd0);
    chk("reset memen", {31'd0, o_memen}, 32'd0);
    chk("reset irdata", o_ir, 32'd0);
    chk("reset drdata", o_dr, 32'd0);
    chk("reset memaddr", o_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    sel = 0;
    @(negedge clk);
    contention();
    @(negedge clk);
    reset_mid_access();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
